// File: rtl/trim_pwm_pkg.sv
// ----------------------------------------------------------------------------
// trim_pwm_pkg
// Shared definitions for the trim PWM sequencer: the per-channel ramp state,
// channel index constants and the counter terminal-value helper.
// ----------------------------------------------------------------------------
package trim_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int CH_PWM1 = 0;
    localparam int CH_PWM2 = 1;

    // Largest value a counter of the given resolution can hold.
    function automatic int unsigned max_count(input int unsigned res);
        return (32'd1 << res) - 32'd1;
    endfunction

endpackage

// File: rtl/trim_pwm_ramp.sv
// ----------------------------------------------------------------------------
// trim_pwm_ramp
// One channel of the trim PWM sequencer. Latches the most recently accepted
// target and walks the active compare value toward it by at most `step`
// counts per PWM period, only at terminal count so a pulse is never cut short.
//
// Ports
//   clock, reset_n : clock and asynchronous active-low reset
//   tc             : terminal count of the shared period counter (en folded in)
//   accept         : a new target is accepted this cycle
//   new_target     : target value accompanying accept
//   step           : maximum compare change per period (0 behaves as 1)
//   cmp            : active compare value
//   busy           : channel is ramping
//   done           : one-cycle pulse when the compare value reaches target
// ----------------------------------------------------------------------------
module trim_pwm_ramp
    import trim_pwm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tc,
    input  logic              accept,
    input  logic [DATA_W-1:0] new_target,
    input  logic [DATA_W-1:0] step,
    output logic [DATA_W-1:0] cmp,
    output logic              busy,
    output logic              done
);

    ramp_state_t       state;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] cmp_next;

    // Move cur toward tgt by min(max(stp,1), |tgt-cur|). One extra bit keeps
    // the signed difference exact, so the result can neither wrap nor
    // overshoot the target.
    function automatic logic [DATA_W-1:0] step_toward(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] tgt,
        input logic [DATA_W-1:0] stp
    );
        logic signed [DATA_W:0] diff;
        logic signed [DATA_W:0] mag;
        logic signed [DATA_W:0] lim;
        logic signed [DATA_W:0] nxt;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DATA_W] ? -diff : diff;
        lim  = (stp == '0) ? {{DATA_W{1'b0}}, 1'b1} : $signed({1'b0, stp});
        if (lim > mag) begin
            lim = mag;
        end
        nxt = diff[DATA_W] ? ($signed({1'b0, cur}) - lim)
                           : ($signed({1'b0, cur}) + lim);
        return nxt[DATA_W-1:0];
    endfunction

    assign cmp_next = step_toward(cmp, target, step);
    assign busy     = (state == RAMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            target <= '0;
            cmp    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                target <= new_target;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (new_target != cmp) begin
                            state <= RAMP;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tc) begin
                        // The step uses the target held before this cycle; a
                        // retarget arriving on the same edge keeps the ramp
                        // alive unless it happens to equal the new value.
                        cmp <= cmp_next;
                        if (cmp_next == target &&
                            (!accept || new_target == cmp_next)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/trim_pwm_sequencer.sv
// ----------------------------------------------------------------------------
// trim_pwm_sequencer
// Dual-output trim PWM: free-running period counter, round-robin arbitration
// of duty updates from two requesters, per-channel bounded ramps and
// registered less-than comparators driving the PWM pins.
//
// Ports
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : counter, ramps and pwm advance only while high
//   req_valid[i]   : requester i offers an update
//   req_ready[i]   : requester i's update is accepted this cycle
//   req_chan[i]    : channel targeted by requester i (0 = pwm1, 1 = pwm2)
//   req_target     : slice i is requester i's compare target
//   step           : maximum compare change per period (0 behaves as 1)
//   count          : current counter value
//   cmp1, cmp2     : active compare values
//   pwm1, pwm2     : registered (count < cmpN)
//   tc             : en && count == MAX
//   busy[c]        : channel c ramping
//   done[c]        : one-cycle pulse when channel c reaches its target
// ----------------------------------------------------------------------------
module trim_pwm_sequencer
    import trim_pwm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                en,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_chan,
    input  logic [2*DATA_W-1:0] req_target,
    input  logic [DATA_W-1:0]   step,
    output logic [DATA_W-1:0]   count,
    output logic [DATA_W-1:0]   cmp1,
    output logic [DATA_W-1:0]   cmp2,
    output logic                pwm1,
    output logic                pwm2,
    output logic                tc,
    output logic [1:0]          busy,
    output logic [1:0]          done
);

    localparam logic [DATA_W-1:0] MAX     = DATA_W'(max_count(DATA_W));
    localparam logic              SEL_CH1 = 1'(CH_PWM1);
    localparam logic              SEL_CH2 = 1'(CH_PWM2);

    logic              rr_ptr;
    logic              collide;
    logic [1:0]        accept;
    logic [DATA_W-1:0] target0;
    logic [DATA_W-1:0] target1;
    logic [DATA_W-1:0] new_target1;
    logic [DATA_W-1:0] new_target2;

    assign target0 = req_target[DATA_W-1:0];
    assign target1 = req_target[2*DATA_W-1:DATA_W];
    assign tc      = en && (count == MAX);

    // Different channels never contend; on a same-channel collision the
    // pointer names the winner.
    always_comb begin
        collide      = (&req_valid) && (req_chan[0] == req_chan[1]);
        req_ready[0] = req_valid[0] && (!collide || !rr_ptr);
        req_ready[1] = req_valid[1] && (!collide ||  rr_ptr);

        accept[0]   = (req_ready[0] && req_chan[0] == SEL_CH1) ||
                      (req_ready[1] && req_chan[1] == SEL_CH1);
        accept[1]   = (req_ready[0] && req_chan[0] == SEL_CH2) ||
                      (req_ready[1] && req_chan[1] == SEL_CH2);
        new_target1 = (req_ready[1] && req_chan[1] == SEL_CH1) ? target1 : target0;
        new_target2 = (req_ready[1] && req_chan[1] == SEL_CH2) ? target1 : target0;
    end

    // A contended grant always goes to rr_ptr, so the loser is its inverse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (collide) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            pwm1  <= 1'b0;
            pwm2  <= 1'b0;
        end else if (en) begin
            count <= count + 1'b1;
            pwm1  <= (count < cmp1);
            pwm2  <= (count < cmp2);
        end
    end

    trim_pwm_ramp #(.DATA_W(DATA_W)) u_ramp1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .tc         (tc),
        .accept     (accept[0]),
        .new_target (new_target1),
        .step       (step),
        .cmp        (cmp1),
        .busy       (busy[0]),
        .done       (done[0])
    );

    trim_pwm_ramp #(.DATA_W(DATA_W)) u_ramp2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .tc         (tc),
        .accept     (accept[1]),
        .new_target (new_target2),
        .step       (step),
        .cmp        (cmp2),
        .busy       (busy[1]),
        .done       (done[1])
    );

endmodule

// File: tb/tb_trim_pwm_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trim_pwm_sequencer
// Directed bench for trim_pwm_sequencer at 8-bit resolution.
// ----------------------------------------------------------------------------
module tb_trim_pwm_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_chan = 2'b00;
    logic [15:0] req_target = 16'd0;
    logic [7:0]  step = 8'd0;
    logic [7:0]  count;
    logic [7:0]  cmp1;
    logic [7:0]  cmp2;
    logic        pwm1;
    logic        pwm2;
    logic        tc;
    logic [1:0]  busy;
    logic [1:0]  done;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    trim_pwm_sequencer #(.DATA_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_chan   (req_chan),
        .req_target (req_target),
        .step       (step),
        .count      (count),
        .cmp1       (cmp1),
        .cmp2       (cmp2),
        .pwm1       (pwm1),
        .pwm2       (pwm2),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until tc is high (bounded), leaving the bench in the tc cycle.
    task automatic run_to_tc();
        int n;
        n = 0;
        while (tc !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) check("tc_reached", {31'd0, tc}, 32'd1);
    endtask

    // Advance through the next terminal count edge.
    task automatic wait_tc();
        run_to_tc();
        tick();
    endtask

    task automatic request(input logic [1:0] v, input logic [1:0] ch,
                           input logic [7:0] t0, input logic [7:0] t1);
        req_valid  = v;
        req_chan   = ch;
        req_target = {t1, t0};
    endtask

    initial begin
        int ntc;
        int hi;
        int act;

        // Reset state
        repeat (2) tick();
        check("rst_count", count, 0);
        check("rst_cmp1", cmp1, 0);
        check("rst_cmp2", cmp2, 0);
        check("rst_pwm", {pwm2, pwm1}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tc", tc, 0);

        // Free-running counter, no requests
        reset_n = 1'b1;
        en      = 1'b1;
        repeat (255) tick();
        check("count_max", count, 255);
        check("tc_at_max", tc, 1);
        tick();
        check("count_wrap", count, 0);
        check("tc_after_wrap", tc, 0);
        ntc = 0;
        act = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (tc) ntc++;
            if (pwm1 || pwm2 || busy != 2'b00) act++;
        end
        check("tc_per_512", ntc, 2);
        check("idle_outputs", act, 0);

        // Single ramp 0 -> 100 with step 40
        step = 8'd40;
        request(2'b01, 2'b00, 8'd100, 8'd0);
        #1;
        check("ready_single", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("busy_rise", busy, 2'b01);
        run_to_tc();
        check("cmp1_hold_to_tc", cmp1, 0);
        tick();
        check("cmp1_step1", cmp1, 40);
        check("pwm1_lag", pwm1, 0);
        tick();
        check("pwm1_rise", pwm1, 1);
        wait_tc();
        check("cmp1_step2", cmp1, 80);
        wait_tc();
        check("cmp1_step3", cmp1, 100);
        check("done_ch0", done, 2'b01);
        check("busy_clear", busy, 2'b00);
        tick();
        check("done_one_cycle", done, 2'b00);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pwm1) hi++;
        end
        check("pwm1_high_100", hi, 100);

        // Same-channel collision, round robin
        request(2'b11, 2'b11, 8'd10, 8'd200);
        #1;
        check("collide_r0_wins", req_ready, 2'b01);
        tick();
        check("busy_ch1", busy, 2'b10);
        check("collide_r1_wins", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        wait_tc();
        check("cmp2_latest_wins", cmp2, 40);
        repeat (4) wait_tc();
        check("cmp2_final", cmp2, 200);
        check("done_ch1", done, 2'b10);

        // Distinct channels both accepted; equal targets give immediate done
        request(2'b11, 2'b10, 8'd100, 8'd200);
        #1;
        check("ready_both", req_ready, 2'b11);
        tick();
        req_valid = 2'b00;
        check("done_equal", done, 2'b11);
        check("busy_equal", busy, 2'b00);

        // Retarget mid-ramp
        step = 8'd50;
        request(2'b01, 2'b00, 8'd0, 8'd0);
        tick();
        req_valid = 2'b00;
        wait_tc();
        check("down_step", cmp1, 50);
        wait_tc();
        check("down_final", cmp1, 0);
        request(2'b01, 2'b00, 8'd200, 8'd0);
        tick();
        req_valid = 2'b00;
        wait_tc();
        check("up_step1", cmp1, 50);
        wait_tc();
        check("up_step2", cmp1, 100);
        request(2'b01, 2'b00, 8'd60, 8'd0);
        tick();
        req_valid = 2'b00;
        wait_tc();
        check("retarget_no_overshoot", cmp1, 60);
        check("retarget_done", done, 2'b01);
        check("retarget_idle", busy, 2'b00);

        // Accept coincident with tc, step of 0
        step = 8'd0;
        request(2'b01, 2'b00, 8'd62, 8'd0);
        tick();
        req_valid = 2'b00;
        run_to_tc();
        request(2'b01, 2'b00, 8'd50, 8'd0);
        tick();
        req_valid = 2'b00;
        check("tc_uses_old_target", cmp1, 61);
        wait_tc();
        check("step0_new_dir", cmp1, 60);
        check("step0_busy", busy, 2'b01);

        // en low freezes everything
        run_to_tc();
        en = 1'b0;
        #1;
        check("tc_gated_by_en", tc, 0);
        repeat (500) tick();
        check("freeze_count", count, 255);
        check("freeze_cmp1", cmp1, 60);
        check("freeze_busy", busy, 2'b01);
        check("freeze_pwm1", pwm1, 0);
        en = 1'b1;
        #1;
        check("tc_resume", tc, 1);
        tick();
        check("resume_step", cmp1, 59);
        check("resume_wrap", count, 0);
        repeat (10) tick();
        check("pwm1_mid", pwm1, 1);
        check("pwm2_mid", pwm2, 1);

        // Asynchronous reset mid-ramp
        #2;
        reset_n = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_cmp1", cmp1, 0);
        check("async_cmp2", cmp2, 0);
        check("async_pwm", {pwm2, pwm1}, 0);
        check("async_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        repeat (300) tick();
        check("target_lost_cmp1", cmp1, 0);
        check("target_lost_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
